// File: rtl/nip_pkg.sv
// ---------------------------------------------------------------------------
// nip_pkg
// Shared definitions for the NIP row-buffer address path:
//   - rb_state_t    : frame FSM state encoding (IDLE, FILL, RUN, FLUSH)
//   - ceil_div      : integer ceiling division used for BRAM counts
//   - clog2_min1    : clog2 clamped to a minimum of 1 bit
//   - rb_pack_sel   : row buffer -> BRAM select for RB_PER_BRAM packing
//   - rb_pack_addr  : (row buffer, column) -> BRAM write address
// ---------------------------------------------------------------------------
package nip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } rb_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Row buffers are packed RB_PER_BRAM to a BRAM. Consecutive buffers
    // share a BRAM and are interleaved by column, so one wide read of a
    // column address returns that pixel from every buffer in the BRAM.
    function automatic int rb_pack_sel(input int wr_rb, input int rb_per_bram);
        return wr_rb / rb_per_bram;
    endfunction

    function automatic int rb_pack_addr(input int wr_rb, input int col,
                                        input int rb_per_bram);
        return col * rb_per_bram + (wr_rb % rb_per_bram);
    endfunction

endpackage

// File: rtl/rb_addr_gen_if.sv
// ---------------------------------------------------------------------------
// rb_addr_gen_if
// Bundles the frame control, external-memory issue, row-buffer write/read
// and debug signals of rb_addr_gen.
//   master : frame controller / surroundings (drives start, frame_base, adv)
//   slave  : rb_addr_gen (drives everything else)
//
// Handshake semantics: start is a single-cycle request that is accepted
// only while the generator is idle (busy=0); frame_base is qualified by an
// accepted start. adv is a per-cycle advance qualifier (low = stall). All
// *_en outputs are valid-only strobes with no backpressure: the data beside
// them is meaningful in exactly the cycles the strobe is high. done is a
// single-cycle completion pulse.
// ---------------------------------------------------------------------------
interface rb_addr_gen_if #(
    parameter int EMEM_AW = 18,
    parameter int BS_W    = 1,
    parameter int WA_W    = 11,
    parameter int RA_W    = 9,
    parameter int RB_W    = 3
);
    import nip_pkg::*;

    logic               start;
    logic [EMEM_AW-1:0] frame_base;
    logic               adv;
    logic               busy;
    logic               done;
    logic               emem_rd_en;
    logic [EMEM_AW-1:0] emem_addr;
    logic               wr_en;
    logic [BS_W-1:0]    wr_bram_sel;
    logic [WA_W-1:0]    wr_addr;
    logic               rd_en;
    logic [RA_W-1:0]    rd_addr;
    logic [RB_W-1:0]    top_rb;
    rb_state_t          dbg_state;

    modport master (
        output start, frame_base, adv,
        input  busy, done, emem_rd_en, emem_addr, wr_en, wr_bram_sel,
               wr_addr, rd_en, rd_addr, top_rb, dbg_state
    );

    modport slave (
        input  start, frame_base, adv,
        output busy, done, emem_rd_en, emem_addr, wr_en, wr_bram_sel,
               wr_addr, rd_en, rd_addr, top_rb, dbg_state
    );

endinterface

// File: rtl/rb_wr_delay.sv
// ---------------------------------------------------------------------------
// rb_wr_delay
// DEPTH-stage shift register carrying {valid, row buffer, column} from the
// issue point to the write point. Shifts every cycle regardless of stalls.
// Ports:
//   clk, rst       : clock, asynchronous active-high clear
//   i_valid/i_rb/i_col : tuple entering the line
//   o_valid/o_rb/o_col : tuple leaving the line DEPTH cycles later
// ---------------------------------------------------------------------------
module rb_wr_delay #(
    parameter int DEPTH = 1,
    parameter int RB_W  = 3,
    parameter int COL_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [RB_W-1:0]  i_rb,
    input  logic [COL_W-1:0] i_col,
    output logic             o_valid,
    output logic [RB_W-1:0]  o_rb,
    output logic [COL_W-1:0] o_col
);

    logic [DEPTH-1:0] r_valid;
    logic [RB_W-1:0]  r_rb  [DEPTH];
    logic [COL_W-1:0] r_col [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rb[i]  <= '0;
                r_col[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_rb[0]    <= i_rb;
            r_col[0]   <= i_col;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_rb[i]    <= r_rb[i-1];
                r_col[i]   <= r_col[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_rb    = r_rb[DEPTH-1];
    assign o_col   = r_col[DEPTH-1];

endmodule

// File: rtl/rb_addr_gen.sv
// ---------------------------------------------------------------------------
// rb_addr_gen
// Row-buffer address generator for the NIP pipeline. Streams one frame from
// external memory, writes each pixel into one of N_RB circularly rotated row
// buffers (packed RB_PER_BRAM per BRAM) MEM_LAT cycles after its read was
// issued, and reads the buffered column in step with each issue once the
// first N_RB rows are in.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rb_addr_gen_if.slave
//          in : start, frame_base, adv
//          out: busy, done, emem_rd_en, emem_addr, wr_en, wr_bram_sel,
//               wr_addr, rd_en, rd_addr, top_rb, dbg_state
// ---------------------------------------------------------------------------
module rb_addr_gen
    import nip_pkg::*;
#(
    parameter int IMG_W       = 512,
    parameter int IMG_H       = 512,
    parameter int N_RB        = 5,
    parameter int RB_PER_BRAM = 4,
    parameter int MEM_LAT     = 1,
    parameter int EMEM_AW     = 18
) (
    input  logic         clk,
    input  logic         rst,
    rb_addr_gen_if.slave bus
);

    localparam int N_BRAM = ceil_div(N_RB, RB_PER_BRAM);
    localparam int WA_W   = clog2_min1(IMG_W * RB_PER_BRAM);
    localparam int RA_W   = clog2_min1(IMG_W);
    localparam int BS_W   = clog2_min1(N_BRAM);
    localparam int RB_W   = clog2_min1(N_RB);
    localparam int ROW_W  = clog2_min1(IMG_H);
    localparam int FL_W   = clog2_min1(MEM_LAT + 1);

    rb_state_t          r_state;
    logic [RA_W-1:0]    r_col;
    logic [ROW_W-1:0]   r_row;
    logic [RB_W-1:0]    r_wr_rb;
    logic [EMEM_AW-1:0] r_addr;
    logic [FL_W-1:0]    r_flush_cnt;

    logic               r_busy;
    logic               r_done;
    logic               r_emem_rd_en;
    logic [EMEM_AW-1:0] r_emem_addr;
    logic               r_wr_en;
    logic [BS_W-1:0]    r_wr_bram_sel;
    logic [WA_W-1:0]    r_wr_addr;
    logic               r_rd_en;
    logic [RA_W-1:0]    r_rd_addr;
    logic [RB_W-1:0]    r_top_rb;

    logic               w_start_acc;
    logic               w_active;
    logic               w_issue;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_fill_end;
    logic [EMEM_AW-1:0] w_cur_addr;
    logic               w_dl_valid;
    logic [RB_W-1:0]    w_dl_rb;
    logic [RA_W-1:0]    w_dl_col;

    assign w_start_acc = (r_state == ST_IDLE) && bus.start;
    assign w_active    = (r_state == ST_FILL) || (r_state == ST_RUN);
    // Pixel (0,0) is issued on the same edge that accepts start, so the
    // first read appears in the cycle right after start.
    assign w_issue     = bus.adv && (w_start_acc || w_active);
    assign w_cur_addr  = w_start_acc ? bus.frame_base : r_addr;
    assign w_last_col  = (r_col == RA_W'(IMG_W - 1));
    assign w_last_row  = (r_row == ROW_W'(IMG_H - 1));
    assign w_fill_end  = (r_row == ROW_W'(N_RB - 1));

    // The tuple enters the line at the issue edge; the extra output register
    // below makes the write strobe lag the visible issue by exactly MEM_LAT.
    rb_wr_delay #(
        .DEPTH (MEM_LAT),
        .RB_W  (RB_W),
        .COL_W (RA_W)
    ) u_wr_delay (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_issue),
        .i_rb    (r_wr_rb),
        .i_col   (r_col),
        .o_valid (w_dl_valid),
        .o_rb    (w_dl_rb),
        .o_col   (w_dl_col)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_wr_rb       <= '0;
            r_addr        <= '0;
            r_flush_cnt   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_emem_rd_en  <= 1'b0;
            r_emem_addr   <= '0;
            r_wr_en       <= 1'b0;
            r_wr_bram_sel <= '0;
            r_wr_addr     <= '0;
            r_rd_en       <= 1'b0;
            r_rd_addr     <= '0;
            r_top_rb      <= '0;
        end else begin
            r_emem_rd_en <= 1'b0;
            r_rd_en      <= 1'b0;
            r_done       <= 1'b0;

            r_wr_en <= w_dl_valid;
            if (w_dl_valid) begin
                r_wr_bram_sel <= BS_W'(rb_pack_sel(int'(w_dl_rb), RB_PER_BRAM));
                r_wr_addr     <= WA_W'(rb_pack_addr(int'(w_dl_rb), int'(w_dl_col),
                                                    RB_PER_BRAM));
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_FILL;
                        r_busy  <= 1'b1;
                        r_addr  <= bus.frame_base;
                    end
                end
                ST_FLUSH: begin
                    // Hold until the last write has left the output register,
                    // so done lands in the cycle after the final wr_en.
                    if (r_flush_cnt == FL_W'(MEM_LAT)) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_flush_cnt <= '0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + FL_W'(1);
                    end
                end
                default: ;
            endcase

            if (w_issue) begin
                r_emem_rd_en <= 1'b1;
                r_emem_addr  <= w_cur_addr;
                r_addr       <= w_cur_addr + EMEM_AW'(1);
                if (r_state == ST_RUN) begin
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= r_col;
                    r_top_rb  <= r_wr_rb;
                end
                if (w_last_col) begin
                    r_col <= '0;
                    if (w_last_row) begin
                        r_row       <= '0;
                        r_wr_rb     <= '0;
                        r_flush_cnt <= '0;
                        r_state     <= ST_FLUSH;
                    end else begin
                        r_row   <= r_row + ROW_W'(1);
                        r_wr_rb <= (r_wr_rb == RB_W'(N_RB - 1)) ? '0
                                                                 : r_wr_rb + RB_W'(1);
                        // RUN rows never equal N_RB-1, so this only fires
                        // at the end of the fill phase.
                        if (w_fill_end) begin
                            r_state <= ST_RUN;
                        end
                    end
                end else begin
                    r_col <= r_col + RA_W'(1);
                end
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.emem_rd_en  = r_emem_rd_en;
    assign bus.emem_addr   = r_emem_addr;
    assign bus.wr_en       = r_wr_en;
    assign bus.wr_bram_sel = r_wr_bram_sel;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.rd_en       = r_rd_en;
    assign bus.rd_addr     = r_rd_addr;
    assign bus.top_rb      = r_top_rb;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_rb_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_rb_addr_gen
// Directed bench for rb_addr_gen with IMG_W=4, IMG_H=8, N_RB=5,
// RB_PER_BRAM=4, MEM_LAT=1. Every issue is checked against base + pixel
// index; every issue queues its expected write tuple and cycle, which the
// matching wr_en pops. Hand-computed points from the frame walk-through are
// checked directly.
// ---------------------------------------------------------------------------
module tb_rb_addr_gen;
    import nip_pkg::*;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 8;
    localparam int N_RB    = 5;
    localparam int RBPB    = 4;
    localparam int MEM_LAT = 1;
    localparam int EMEM_AW = 18;
    localparam int WA_W    = clog2_min1(IMG_W * RBPB);
    localparam int RA_W    = clog2_min1(IMG_W);
    localparam int BS_W    = clog2_min1(ceil_div(N_RB, RBPB));
    localparam int RB_W    = clog2_min1(N_RB);
    localparam int EXP_W   = 16 + BS_W + WA_W;
    localparam int N_PIX   = IMG_W * IMG_H;

    logic clk;
    logic rst;

    rb_addr_gen_if #(
        .EMEM_AW (EMEM_AW),
        .BS_W    (BS_W),
        .WA_W    (WA_W),
        .RA_W    (RA_W),
        .RB_W    (RB_W)
    ) bus_if ();

    rb_addr_gen #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .N_RB        (N_RB),
        .RB_PER_BRAM (RBPB),
        .MEM_LAT     (MEM_LAT),
        .EMEM_AW     (EMEM_AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int                 n_tests = 0;
    int                 n_fail  = 0;
    int                 cyc     = 0;
    int                 k       = 0;
    int                 n_issue = 0;
    int                 n_wr    = 0;
    logic [EMEM_AW-1:0] cur_base;
    logic [EXP_W-1:0]   exp_q[$];

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_busy"},        32'(bus_if.busy),        0);
        check_eq({pfx, "_done"},        32'(bus_if.done),        0);
        check_eq({pfx, "_emem_rd_en"},  32'(bus_if.emem_rd_en),  0);
        check_eq({pfx, "_emem_addr"},   32'(bus_if.emem_addr),   0);
        check_eq({pfx, "_wr_en"},       32'(bus_if.wr_en),       0);
        check_eq({pfx, "_wr_bram_sel"}, 32'(bus_if.wr_bram_sel), 0);
        check_eq({pfx, "_wr_addr"},     32'(bus_if.wr_addr),     0);
        check_eq({pfx, "_rd_en"},       32'(bus_if.rd_en),       0);
        check_eq({pfx, "_rd_addr"},     32'(bus_if.rd_addr),     0);
        check_eq({pfx, "_top_rb"},      32'(bus_if.top_rb),      0);
        check_eq({pfx, "_state"},       32'(bus_if.dbg_state),   32'(ST_IDLE));
    endtask

    // Scoreboard: writes are matched before this cycle's issue is queued.
    task automatic monitor();
        int               row;
        int               col;
        int               rb;
        logic [EXP_W-1:0] e;
        logic [15:0]      lag;
        if (bus_if.wr_en) begin
            n_wr++;
            check_eq("wr_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                lag = cyc[15:0] - e[WA_W+BS_W +: 16];
                check_eq("wr_lag",      32'(lag),                MEM_LAT);
                check_eq("wr_bram_sel", 32'(bus_if.wr_bram_sel), 32'(e[WA_W +: BS_W]));
                check_eq("wr_addr",     32'(bus_if.wr_addr),     32'(e[WA_W-1:0]));
            end
        end
        if (bus_if.emem_rd_en) begin
            row = k / IMG_W;
            col = k % IMG_W;
            rb  = row % N_RB;
            n_issue++;
            check_eq("issue_addr", 32'(bus_if.emem_addr), 32'(cur_base + EMEM_AW'(k)));
            check_eq("issue_rd_en", 32'(bus_if.rd_en), 32'(row >= N_RB));
            if (row >= N_RB) begin
                check_eq("issue_rd_addr", 32'(bus_if.rd_addr), 32'(col));
                check_eq("issue_top_rb",  32'(bus_if.top_rb),  32'(rb));
            end
            e = {cyc[15:0], BS_W'(rb / RBPB), WA_W'(col * RBPB + rb % RBPB)};
            exp_q.push_back(e);
            k++;
        end else begin
            check_eq("rd_idle", 32'(bus_if.rd_en), 0);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            monitor();
        end
    endtask

    task automatic start_frame(input logic [EMEM_AW-1:0] base);
        cur_base          = base;
        k                 = 0;
        n_issue           = 0;
        n_wr              = 0;
        bus_if.frame_base = base;
        bus_if.start      = 1'b1;
        bus_if.adv        = 1'b1;
        step();
        monitor();
        bus_if.start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            monitor();
            if (bus_if.done) begin
                seen = 1'b1;
                check_eq("done_busy_low", 32'(bus_if.busy), 0);
            end
        end
        check_eq("done_seen", 32'(seen), 1);
    endtask

    task automatic check_frame_counts(input string pfx);
        check_eq({pfx, "_issues"}, 32'(n_issue), N_PIX);
        check_eq({pfx, "_writes"}, 32'(n_wr),    N_PIX);
        check_eq({pfx, "_q_empty"}, 32'(exp_q.size()), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst               = 1'b0;
        bus_if.start      = 1'b0;
        bus_if.frame_base = '0;
        bus_if.adv        = 1'b0;

        // Reset with no clock edge yet, then start held during reset.
        #1 rst = 1'b1;
        #1 check_outputs_zero("rst_noclk");
        bus_if.start      = 1'b1;
        bus_if.frame_base = 18'd55;
        step();
        step();
        rst          = 1'b0;
        bus_if.start = 1'b0;
        step();
        monitor();
        check_eq("rst_start_ignored_busy",  32'(bus_if.busy),      0);
        check_eq("rst_start_ignored_state", 32'(bus_if.dbg_state), 32'(ST_IDLE));

        // Frame 1: base 100, adv held high.
        start_frame(18'd100);
        check_eq("f1_busy", 32'(bus_if.busy), 1);
        run(2);
        check_eq("r0c2_emem_addr", 32'(bus_if.emem_addr), 102);
        check_eq("r0c2_fill_rd",   32'(bus_if.rd_en),     0);
        run(1);
        check_eq("r0c2_wr_en",  32'(bus_if.wr_en),       1);
        check_eq("r0c2_wr_sel", 32'(bus_if.wr_bram_sel), 0);
        check_eq("r0c2_wr_addr", 32'(bus_if.wr_addr),    8);
        run(14);
        run(1);
        check_eq("r4c1_wr_sel",  32'(bus_if.wr_bram_sel), 1);
        check_eq("r4c1_wr_addr", 32'(bus_if.wr_addr),     4);
        run(2);
        check_eq("r5c0_rd_en",   32'(bus_if.rd_en),   1);
        check_eq("r5c0_rd_addr", 32'(bus_if.rd_addr), 0);
        check_eq("r5c0_top_rb",  32'(bus_if.top_rb),  0);
        check_eq("r5c0_state",   32'(bus_if.dbg_state), 32'(ST_RUN));
        run(1);
        check_eq("r5c0_wr_en",   32'(bus_if.wr_en),       1);
        check_eq("r5c0_wr_sel",  32'(bus_if.wr_bram_sel), 0);
        check_eq("r5c0_wr_addr", 32'(bus_if.wr_addr),     0);
        run(6);
        check_eq("r6c3_top_rb", 32'(bus_if.top_rb), 1);
        run(1);
        check_eq("r6c3_wr_addr", 32'(bus_if.wr_addr), 13);
        run(3);
        check_eq("r7c3_emem_addr", 32'(bus_if.emem_addr), 131);
        run(1);
        check_eq("last_wr_en",    32'(bus_if.wr_en),      1);
        check_eq("last_wr_noiss", 32'(bus_if.emem_rd_en), 0);
        check_eq("last_wr_busy",  32'(bus_if.busy),       1);
        check_eq("last_wr_done",  32'(bus_if.done),       0);
        run(1);
        check_eq("eof_done",  32'(bus_if.done),  1);
        check_eq("eof_busy",  32'(bus_if.busy),  0);
        check_eq("eof_wr_en", 32'(bus_if.wr_en), 0);
        run(1);
        check_eq("eof_done_pulse", 32'(bus_if.done), 0);
        check_frame_counts("f1");

        // Frame 2: stall for 3 cycles after (r2,c1).
        start_frame(18'd101);
        run(9);
        check_eq("stall_r2c1_addr", 32'(bus_if.emem_addr), 110);
        bus_if.adv = 1'b0;
        run(1);
        check_eq("stall_no_issue0", 32'(bus_if.emem_rd_en),  0);
        check_eq("stall_wr_lands",  32'(bus_if.wr_en),       1);
        check_eq("stall_wr_sel",    32'(bus_if.wr_bram_sel), 0);
        check_eq("stall_wr_addr",   32'(bus_if.wr_addr),     6);
        for (int i = 0; i < 2; i++) begin
            run(1);
            check_eq("stall_no_issue", 32'(bus_if.emem_rd_en), 0);
            check_eq("stall_no_wr",    32'(bus_if.wr_en),      0);
        end
        bus_if.adv = 1'b1;
        run(1);
        check_eq("stall_resume_addr", 32'(bus_if.emem_addr), 111);
        wait_done(60);
        check_frame_counts("f2");

        // Frame 3: reset in the middle of row 6.
        start_frame(18'd100);
        run(24);
        check_eq("pre_rst_rd_en", 32'(bus_if.rd_en), 1);
        rst          = 1'b1;
        bus_if.start = 1'b1;
        #1 check_outputs_zero("midrst");
        exp_q.delete();
        k = 0;
        step();
        step();
        rst          = 1'b0;
        bus_if.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("midrst_no_trailing_wr", 32'(bus_if.wr_en), 0);
            check_eq("midrst_idle_busy",      32'(bus_if.busy),  0);
        end

        // Frame 4: restart after reset resumes from row 0.
        start_frame(18'd300);
        check_eq("restart_addr", 32'(bus_if.emem_addr), 300);
        run(1);
        check_eq("restart_wr_en",   32'(bus_if.wr_en),       1);
        check_eq("restart_wr_sel",  32'(bus_if.wr_bram_sel), 0);
        check_eq("restart_wr_addr", 32'(bus_if.wr_addr),     0);
        wait_done(60);
        check_frame_counts("f4");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
